reset_seq_gen: RTL and testbench

Parametrised successor to the single-stage system reset network. It accepts NUM_SRC reset sources, each with an optional glitch filter, and holds all outputs until every enabled source is quiet plus HOLD_CYCLES. It then releases NUM_OUT reset domains in staged order, STAGE_GAP cycles apart, and records which source caused each re-entry. It sits at top level between PLL/BMC/PCIe reset sources and the platform subsystem reset inputs.

---
 rtl/reset_seq_gen.sv | 167 ++++++++++++++++
 tb/tb_reset_seq_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_seq_gen.sv
// rtl/reset_seq_gen.sv - multi-source reset sequencer with glitch filtering,
// hold-off and staged, ascending-order release of NUM_OUT reset domains.
module reset_seq_gen #(
  parameter int                 NUM_SRC     = 4,
  parameter int                 NUM_OUT     = 4,
  parameter int                 HOLD_CYCLES = 256,
  parameter int                 STAGE_GAP   = 16,
  parameter int                 FILT_CYCLES = 8,
  parameter logic [NUM_SRC-1:0] FILT_MASK   = NUM_SRC'(4'b0010),
  parameter int                 CNT_W       = 32
) (
  input  logic               sys_clk,
  input  logic               sys_reset,
  input  logic [NUM_SRC-1:0] src_reset,
  input  logic [NUM_SRC-1:0] src_enable,
  input  logic               sw_reset,
  input  logic               cause_clr,
  output logic [NUM_OUT-1:0] rst_out,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               all_released,
  output logic [NUM_SRC-1:0] cause,
  output logic               sw_cause,
  output logic [1:0]         state
);

  localparam int HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam int FILT_W   = $clog2(FILT_CYCLES + 1);
  localparam int IDX_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
  localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(FILT_CYCLES);
  localparam logic [FILT_W-1:0] FILT_ARM  = FILT_W'(FILT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_STAGE  = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  logic [NUM_SRC-1:0] s1;
  logic [NUM_SRC-1:0] s2;
  logic [NUM_SRC-1:0] act;
  logic [FILT_W-1:0]  filt_cnt [NUM_SRC];

  // act is registered so unfiltered sources see sync+1 latency; filtered ones
  // arm from the pre-increment count so they land at sync+FILT_CYCLES.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      s1  <= '0;
      s2  <= '0;
      act <= '0;
      for (int i = 0; i < NUM_SRC; i++) filt_cnt[i] <= '0;
    end else begin
      s1 <= src_reset;
      s2 <= s1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (FILT_MASK[i]) begin
          if (s2[i]) begin
            if (filt_cnt[i] != FILT_MAX) filt_cnt[i] <= filt_cnt[i] + 1'b1;
            act[i] <= (filt_cnt[i] >= FILT_ARM);
          end else begin
            filt_cnt[i] <= '0;
            act[i]      <= 1'b0;
          end
        end else begin
          filt_cnt[i] <= '0;
          act[i]      <= s2[i];
        end
      end
    end
  end

  logic [NUM_SRC-1:0] act_en;
  logic               src_trig;
  logic               trig;

  assign act_en   = act & src_enable;
  assign src_trig = |act_en;
  assign trig     = src_trig | sw_reset;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  assign state = st;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      st           <= ST_ASSERT;
      cnt          <= '0;
      idx          <= '0;
      rst_out      <= '1;
      rst_out_n    <= '0;
      all_released <= 1'b0;
      cause        <= '0;
      sw_cause     <= 1'b0;
    end else if (st != ST_ASSERT && trig) begin
      // Any partial sequence restarts from scratch; new cause bits win over clear.
      st           <= ST_ASSERT;
      cnt          <= '0;
      idx          <= '0;
      rst_out      <= '1;
      rst_out_n    <= '0;
      all_released <= 1'b0;
      cause        <= (cause_clr ? '0 : cause) | act_en;
      sw_cause     <= (cause_clr ? 1'b0 : sw_cause) | sw_reset;
    end else begin
      if (cause_clr) begin
        cause    <= '0;
        sw_cause <= 1'b0;
      end
      case (st)
        ST_ASSERT: begin
          rst_out      <= '1;
          rst_out_n    <= '0;
          all_released <= 1'b0;
          if (!src_trig) begin
            st  <= ST_HOLD;
            cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt <= '0;
            if (NUM_OUT == 1 || STAGE_GAP == 0) begin
              rst_out      <= '0;
              rst_out_n    <= '1;
              all_released <= 1'b1;
              st           <= ST_RUN;
            end else begin
              rst_out[0]   <= 1'b0;
              rst_out_n[0] <= 1'b1;
              idx          <= IDX_W'(1);
              st           <= ST_STAGE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STAGE: begin
          if (cnt == GAP_LAST) begin
            cnt            <= '0;
            rst_out[idx]   <= 1'b0;
            rst_out_n[idx] <= 1'b1;
            if (idx == LAST_IDX) begin
              all_released <= 1'b1;
              st           <= ST_RUN;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          rst_out      <= '0;
          rst_out_n    <= '1;
          all_released <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq_gen.sv
// tb/tb_reset_seq_gen.sv - scoreboard bench for reset_seq_gen: expected output
// changes and status snapshots are queued by stimulus and matched by a monitor.
module tb_reset_seq_gen;

  localparam int HOLD = 256;
  localparam int GAP  = 16;

  localparam logic [1:0] S_ASSERT = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd3;

  logic       sys_clk = 1'b0;
  logic       sys_reset;
  logic [3:0] src_reset;
  logic [3:0] src_enable;
  logic       sw_reset;
  logic       cause_clr;
  logic [3:0] rst_out;
  logic [3:0] rst_out_n;
  logic       all_released;
  logic [3:0] cause;
  logic       sw_cause;
  logic [1:0] state;

  reset_seq_gen dut (
    .sys_clk      (sys_clk),
    .sys_reset    (sys_reset),
    .src_reset    (src_reset),
    .src_enable   (src_enable),
    .sw_reset     (sw_reset),
    .cause_clr    (cause_clr),
    .rst_out      (rst_out),
    .rst_out_n    (rst_out_n),
    .all_released (all_released),
    .cause        (cause),
    .sw_cause     (sw_cause),
    .state        (state)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic       ar;
  } rst_exp_t;

  typedef struct {
    int         cyc;
    logic [3:0] cause;
    logic       sw;
    logic [1:0] st;
  } stat_exp_t;

  rst_exp_t  rq[$];
  stat_exp_t sq[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic push_rst(input int c, input logic [3:0] v, input logic ar);
    rst_exp_t e;
    e.cyc = c; e.rst = v; e.ar = ar;
    rq.push_back(e);
  endtask

  task automatic push_stat(input int c, input logic [3:0] ca, input logic sw, input logic [1:0] st);
    stat_exp_t e;
    e.cyc = c; e.cause = ca; e.sw = sw; e.st = st;
    sq.push_back(e);
  endtask

  // Release schedule of the default configuration, HOLD entered at edge h.
  task automatic push_seq(input int h, input int k);
    logic [3:0] v;
    v = 4'hF;
    for (int i = 0; i < k; i++) begin
      v[i] = 1'b0;
      push_rst(h + HOLD + GAP * i, v, i == 3);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  logic [4:0] prev_obs = 5'bx;

  always @(negedge sys_clk) begin
    rst_exp_t  r;
    stat_exp_t s;
    if ({rst_out, all_released} !== prev_obs) begin
      n_checks++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got rst_out=%h all_released=%b", cyc, rst_out, all_released);
      end else begin
        r = rq.pop_front();
        if (r.cyc != cyc || r.rst !== rst_out || r.ar !== all_released || rst_out_n !== ~r.rst) begin
          n_fail++;
          $display("FAIL rst_event cyc=%0d got rst_out=%h rst_out_n=%h all_released=%b; expected cyc=%0d rst_out=%h all_released=%b",
                   cyc, rst_out, rst_out_n, all_released, r.cyc, r.rst, r.ar);
        end
      end
      prev_obs = {rst_out, all_released};
    end
    while (rq.size() != 0 && rq[0].cyc < cyc) begin
      r = rq.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_rst_event cyc=%0d got rst_out=%h; expected at cyc=%0d rst_out=%h", cyc, rst_out, r.cyc, r.rst);
    end
    while (sq.size() != 0 && sq[0].cyc <= cyc) begin
      s = sq.pop_front();
      n_checks++;
      if (s.cyc != cyc || s.cause !== cause || s.sw !== sw_cause || s.st !== state) begin
        n_fail++;
        $display("FAIL status cyc=%0d got cause=%b sw_cause=%b state=%0d; expected cyc=%0d cause=%b sw_cause=%b state=%0d",
                 cyc, cause, sw_cause, state, s.cyc, s.cause, s.sw, s.st);
      end
    end
  end

  initial begin
    int c, n, h, r;
    sys_reset  = 1'b1;
    src_reset  = 4'h0;
    src_enable = 4'hF;
    sw_reset   = 1'b0;
    cause_clr  = 1'b0;

    // Reset state, then the plain power-on sequence.
    push_rst(1, 4'hF, 1'b0);
    push_stat(1, 4'h0, 1'b0, S_ASSERT);
    goto(3);
    sys_reset = 1'b0;
    push_stat(4, 4'h0, 1'b0, S_HOLD);
    push_seq(4, 4);
    push_stat(3 + 305, 4'h0, 1'b0, S_RUN);
    goto(3 + 310);

    // Filtered source: 5-cycle glitch ignored, 8-cycle pulse fires at +10.
    c = cyc;
    src_reset[1] = 1'b1;
    goto(c + 5);
    src_reset[1] = 1'b0;
    push_stat(c + 20, 4'h0, 1'b0, S_RUN);
    goto(c + 22);
    c = cyc; n = c + 1;
    src_reset[1] = 1'b1;
    push_rst(n + 10, 4'hF, 1'b0);
    push_stat(n + 10, 4'b0010, 1'b0, S_ASSERT);
    push_stat(n + 11, 4'b0010, 1'b0, S_HOLD);
    push_seq(n + 11, 2);
    goto(c + 8);
    src_reset[1] = 1'b0;
    h = n + 11;
    goto(h + 275);

    // Unfiltered single-cycle pulse mid-STAGE restarts the whole sequence.
    c = cyc; n = c + 1;
    src_reset[0] = 1'b1;
    push_rst(n + 3, 4'hF, 1'b0);
    push_stat(n + 3, 4'b0011, 1'b0, S_ASSERT);
    push_seq(n + 4, 4);
    goto(c + 1);
    src_reset[0] = 1'b0;
    h = n + 4;
    goto(h + 310);

    // Disabled source held high is ignored until enabled.
    c = cyc;
    src_enable[2] = 1'b0;
    src_reset[2]  = 1'b1;
    push_stat(c + 12, 4'b0011, 1'b0, S_RUN);
    goto(c + 15);
    c = cyc;
    src_enable[2] = 1'b1;
    push_rst(c + 1, 4'hF, 1'b0);
    push_stat(c + 1, 4'b0111, 1'b0, S_ASSERT);
    goto(c + 6);
    c = cyc;
    src_reset[2] = 1'b0;
    push_stat(c + 3, 4'b0111, 1'b0, S_ASSERT);
    push_stat(c + 4, 4'b0111, 1'b0, S_HOLD);
    push_seq(c + 4, 4);
    h = c + 4;
    goto(h + 310);

    // Software reset with coincident cause_clr.
    c = cyc;
    sw_reset  = 1'b1;
    cause_clr = 1'b1;
    push_rst(c + 1, 4'hF, 1'b0);
    push_stat(c + 1, 4'h0, 1'b1, S_ASSERT);
    push_stat(c + 2, 4'h0, 1'b1, S_HOLD);
    goto(c + 1);
    sw_reset  = 1'b0;
    cause_clr = 1'b0;
    goto(c + 102);

    // Asynchronous sys_reset mid-HOLD clears cause and restarts.
    @(posedge sys_clk);
    #2;
    r = cyc;
    sys_reset = 1'b1;
    push_stat(r, 4'h0, 1'b0, S_ASSERT);
    goto(r + 2);
    sys_reset = 1'b0;
    push_stat(r + 3, 4'h0, 1'b0, S_HOLD);
    push_seq(r + 3, 4);
    push_stat(r + 3 + 305, 4'h0, 1'b0, S_RUN);
    goto(r + 3 + 310);

    n_checks++;
    if (rq.size() != 0 || sq.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations got rst=%0d stat=%0d expected 0 0", rq.size(), sq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
